// File: rtl/dsi_lane_if.sv
`default_nettype none
// ============================================================================
// Module   : dsi_lane_if
// Brief    : Payload request/handshake bundle feeding one DSI lane sequencer.
//            master = byte source, slave = lane sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface dsi_lane_if;
  logic       tx_req;    // level request to start a burst
  logic [7:0] tx_data;   // payload byte, bit 0 transmitted first
  logic       tx_valid;  // tx_data valid
  logic       tx_last;   // final payload byte, qualified by tx_valid
  logic       tx_ready;  // sequencer is in DATA and can take a byte

  modport master (output tx_req, tx_data, tx_valid, tx_last, input tx_ready);
  modport slave  (input tx_req, tx_data, tx_valid, tx_last, output tx_ready);
endinterface
`default_nettype wire

// File: rtl/dsi_lane_seq.sv
`default_nettype none
// ============================================================================
// Module   : dsi_lane_seq
// Brief    : Single DSI data-lane sequencer (byte_clk domain). Runs LP-11 ->
//            LP-01 -> LP-00 -> HS-0 -> sync -> payload -> trail -> LP-11,
//            driving LP levels, HS enable, serializer reset and HS bytes.
//            Optional: define DSI_LANE_BYTECNT_EN to add hs_byte_cnt[15:0].
// Revision : 1.0 - initial release
// ============================================================================
module dsi_lane_seq #(
  parameter int CW           = 8,
  parameter int T_LPX        = 2,
  parameter int T_HS_PREPARE = 3,
  parameter int T_HS_ZERO    = 6,
  parameter int T_HS_TRAIL   = 4,
  parameter int T_HS_EXIT    = 5
) (
  input  wire logic  byte_clk,
  input  wire logic  rst_n,
  dsi_lane_if.slave  tx,
  output logic [7:0] hs_data,
  output logic       hs_oe,
  output logic       ser_rst,
  output logic       lp_p,
  output logic       lp_n,
  output logic       busy,
  output logic       done,
  output logic       underrun
`ifdef DSI_LANE_BYTECNT_EN
  ,
  output logic [15:0] hs_byte_cnt
`endif
);

  localparam logic [7:0]    c_sync_byte  = 8'hB8;
  localparam logic [CW-1:0] c_lpx_load   = CW'(T_LPX - 1);
  localparam logic [CW-1:0] c_prep_load  = CW'(T_HS_PREPARE - 1);
  localparam logic [CW-1:0] c_zero_load  = CW'(T_HS_ZERO - 1);
  localparam logic [CW-1:0] c_trail_load = CW'(T_HS_TRAIL - 1);
  localparam logic [CW-1:0] c_exit_load  = CW'(T_HS_EXIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LPX   = 3'd1,
    S_PREP  = 3'd2,
    S_ZERO  = 3'd3,
    S_SYNC  = 3'd4,
    S_DATA  = 3'd5,
    S_TRAIL = 3'd6,
    S_EXIT  = 3'd7
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_timer;
  logic [CW-1:0] w_timer_load;
  logic [7:0]    r_last_byte;
  logic [7:0]    w_trail_byte;
  logic          w_accept;
  logic          w_lp_p;
  logic          w_lp_n;
  logic          w_hs_oe;
  logic          w_ser_rst;
  logic [7:0]    w_hs_data;
  logic          r_tx_ready;

  assign tx.tx_ready  = r_tx_ready;
  // Trail is the complement of the last bit sent, held for the whole trail.
  assign w_trail_byte = {8{~r_last_byte[7]}};

  // Timed phases must last at least one cycle and fit in the timer.
  always_ff @(posedge byte_clk) begin
    assert (T_LPX >= 1 && T_HS_PREPARE >= 1 && T_HS_ZERO >= 1 &&
            T_HS_TRAIL >= 1 && T_HS_EXIT >= 1 &&
            T_LPX < (1 << CW) && T_HS_PREPARE < (1 << CW) &&
            T_HS_ZERO < (1 << CW) && T_HS_TRAIL < (1 << CW) &&
            T_HS_EXIT < (1 << CW))
      else $error("dsi_lane_seq: timing parameter outside 1..2^CW-1");
  end

  // State register.
  always_ff @(posedge byte_clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state, timer reload value and the lane levels this state produces.
  always_comb begin
    w_state_nxt  = r_state;
    w_timer_load = '0;
    w_accept     = 1'b0;
    w_lp_p       = 1'b1;
    w_lp_n       = 1'b1;
    w_hs_oe      = 1'b0;
    w_ser_rst    = 1'b1;
    w_hs_data    = 8'h00;
    case (r_state)
      S_IDLE: if (tx.tx_req) w_state_nxt = S_LPX;
      S_LPX: begin
        w_lp_p = 1'b0;
        if (r_timer == '0) w_state_nxt = S_PREP;
      end
      S_PREP: begin
        w_lp_p = 1'b0;
        w_lp_n = 1'b0;
        if (r_timer == '0) w_state_nxt = S_ZERO;
      end
      S_ZERO: begin
        {w_lp_p, w_lp_n, w_hs_oe, w_ser_rst} = 4'b0010;
        if (r_timer == '0) w_state_nxt = S_SYNC;
      end
      S_SYNC: begin
        {w_lp_p, w_lp_n, w_hs_oe, w_ser_rst} = 4'b0010;
        w_hs_data   = c_sync_byte;
        w_state_nxt = S_DATA;
      end
      S_DATA: begin
        {w_lp_p, w_lp_n, w_hs_oe, w_ser_rst} = 4'b0010;
        if (tx.tx_valid) begin
          w_accept  = 1'b1;
          w_hs_data = tx.tx_data;
          if (tx.tx_last) w_state_nxt = S_TRAIL;
        end else begin
          // Source ran dry: the stall cycle already carries the trail byte.
          w_hs_data   = w_trail_byte;
          w_state_nxt = S_TRAIL;
        end
      end
      S_TRAIL: begin
        {w_lp_p, w_lp_n, w_hs_oe, w_ser_rst} = 4'b0010;
        w_hs_data = w_trail_byte;
        if (r_timer == '0) w_state_nxt = S_EXIT;
      end
      S_EXIT: if (r_timer == '0) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    case (w_state_nxt)
      S_LPX:   w_timer_load = c_lpx_load;
      S_PREP:  w_timer_load = c_prep_load;
      S_ZERO:  w_timer_load = c_zero_load;
      S_TRAIL: w_timer_load = c_trail_load;
      S_EXIT:  w_timer_load = c_exit_load;
      default: w_timer_load = '0;
    endcase
  end

  // Phase timer: reload on every state change, count down to zero otherwise.
  always_ff @(posedge byte_clk or negedge rst_n) begin
    if (!rst_n)                       r_timer <= '0;
    else if (w_state_nxt != r_state)  r_timer <= w_timer_load;
    else if (r_timer != '0)           r_timer <= r_timer - CW'(1);
  end

  // Last byte handed to the serializer; seeded with sync so an empty burst trails correctly.
  always_ff @(posedge byte_clk or negedge rst_n) begin
    if (!rst_n)                                        r_last_byte <= c_sync_byte;
    else if (w_state_nxt == S_SYNC && r_state != S_SYNC) r_last_byte <= c_sync_byte;
    else if (w_accept)                                 r_last_byte <= tx.tx_data;
  end

  // Lane outputs: one register stage behind the state that selected them.
  always_ff @(posedge byte_clk or negedge rst_n) begin
    if (!rst_n) begin
      lp_p    <= 1'b1;
      lp_n    <= 1'b1;
      hs_oe   <= 1'b0;
      ser_rst <= 1'b1;
      hs_data <= 8'h00;
    end else begin
      lp_p    <= w_lp_p;
      lp_n    <= w_lp_n;
      hs_oe   <= w_hs_oe;
      ser_rst <= w_ser_rst;
      hs_data <= w_hs_data;
    end
  end

  // Control/status outputs aligned with the state they describe.
  always_ff @(posedge byte_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      r_tx_ready <= (w_state_nxt == S_DATA);
      busy       <= (w_state_nxt != S_IDLE);
      done       <= (r_state == S_EXIT) && (w_state_nxt == S_IDLE);
      underrun   <= (r_state == S_DATA) && !tx.tx_valid;
    end
  end

`ifdef DSI_LANE_BYTECNT_EN
  // Payload byte counter: cleared on sync entry, held after the burst.
  always_ff @(posedge byte_clk or negedge rst_n) begin
    if (!rst_n)                                        hs_byte_cnt <= 16'h0000;
    else if (w_state_nxt == S_SYNC && r_state != S_SYNC) hs_byte_cnt <= 16'h0000;
    else if (w_accept)                                 hs_byte_cnt <= hs_byte_cnt + 16'h0001;
  end
`else
`endif

endmodule
`default_nettype wire

// File: tb/tb_dsi_lane_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_dsi_lane_seq
// Brief    : Self-checking bench for dsi_lane_seq. Expected lane traces are
//            built from the phase durations as a per-cycle queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dsi_lane_seq;
  localparam int CW      = 8;
  localparam int T_LPX   = 2;
  localparam int T_PREP  = 3;
  localparam int T_ZERO  = 6;
  localparam int T_TRAIL = 4;
  localparam int T_EXIT  = 5;

  // {lp_p, lp_n, hs_oe, ser_rst} patterns of the lane
  localparam logic [3:0] P_LP11 = 4'b1101;
  localparam logic [3:0] P_LP01 = 4'b0101;
  localparam logic [3:0] P_LP00 = 4'b0001;
  localparam logic [3:0] P_HS   = 4'b0010;

  logic       byte_clk = 1'b0;
  logic       rst_n    = 1'b1;
  logic [7:0] hs_data;
  logic       hs_oe, ser_rst, lp_p, lp_n, busy, done, underrun;
`ifdef DSI_LANE_BYTECNT_EN
  logic [15:0] hs_byte_cnt;
`endif

  dsi_lane_if tx_if ();

  dsi_lane_seq #(
    .CW(CW), .T_LPX(T_LPX), .T_HS_PREPARE(T_PREP), .T_HS_ZERO(T_ZERO),
    .T_HS_TRAIL(T_TRAIL), .T_HS_EXIT(T_EXIT)
  ) dut (
    .byte_clk (byte_clk),
    .rst_n    (rst_n),
    .tx       (tx_if),
    .hs_data  (hs_data),
    .hs_oe    (hs_oe),
    .ser_rst  (ser_rst),
    .lp_p     (lp_p),
    .lp_n     (lp_n),
    .busy     (busy),
    .done     (done),
    .underrun (underrun)
`ifdef DSI_LANE_BYTECNT_EN
    ,
    .hs_byte_cnt (hs_byte_cnt)
`endif
  );

  always #5 byte_clk = ~byte_clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge byte_clk);
    #1;
  endtask

  function automatic logic [11:0] lane_now();
    return {lp_p, lp_n, hs_oe, ser_rst, hs_data};
  endfunction

  // One burst from the request edge through the done cycle. c=0 is the first
  // cycle after tx_req is sampled. Lane levels trail the phase by one cycle.
  task automatic run_burst(input logic [7:0] pl [8], input int n, input bit und,
                           input bit hold, input string name);
    logic [11:0] exp_lane[$];
    logic [7:0]  lb, tb;
    int          dstart, dlen, total, idx;
    bit          prev_acc;

    lb = (n > 0) ? pl[n-1] : 8'hB8;
    tb = {8{~lb[7]}};
    exp_lane.push_back({P_LP11, 8'h00});
    repeat (T_LPX)  exp_lane.push_back({P_LP01, 8'h00});
    repeat (T_PREP) exp_lane.push_back({P_LP00, 8'h00});
    repeat (T_ZERO) exp_lane.push_back({P_HS, 8'h00});
    exp_lane.push_back({P_HS, 8'hB8});
    for (int i = 0; i < n; i++) exp_lane.push_back({P_HS, pl[i]});
    repeat (T_TRAIL + (und ? 1 : 0)) exp_lane.push_back({P_HS, tb});
    repeat (T_EXIT) exp_lane.push_back({P_LP11, 8'h00});

    dstart = T_LPX + T_PREP + T_ZERO + 1;
    dlen   = n + (und ? 1 : 0);
    total  = dstart + dlen + T_TRAIL + T_EXIT;

    idx = 0;
    tx_if.tx_req   = 1'b1;
    tx_if.tx_valid = (n > 0);
    tx_if.tx_data  = pl[0];
    tx_if.tx_last  = !und && (n == 1);
    prev_acc = 1'b0;

    for (int c = 0; c <= total; c++) begin
      step();
      if (prev_acc) idx++;
      chk($sformatf("%s_c%0d_lane", name, c), {20'd0, lane_now()}, {20'd0, exp_lane[c]});
      chk($sformatf("%s_c%0d_ready", name, c), {31'd0, tx_if.tx_ready},
          {31'd0, (c >= dstart && c < dstart + dlen)});
      chk($sformatf("%s_c%0d_busy", name, c), {31'd0, busy}, {31'd0, (c < total)});
      chk($sformatf("%s_c%0d_done", name, c), {31'd0, done}, {31'd0, (c == total)});
      chk($sformatf("%s_c%0d_underrun", name, c), {31'd0, underrun},
          {31'd0, (und && c == dstart + dlen)});
      if (!hold) tx_if.tx_req = 1'b0;
      tx_if.tx_valid = (idx < n);
      tx_if.tx_data  = (idx < n) ? pl[idx] : 8'h00;
      tx_if.tx_last  = !und && (idx == n - 1);
      prev_acc = tx_if.tx_ready && tx_if.tx_valid;
    end
    chk({name, "_consumed"}, idx, n);
`ifdef DSI_LANE_BYTECNT_EN
    chk({name, "_bytecnt"}, {16'd0, hs_byte_cnt}, n);
`endif
  endtask

  // Safety net in case the bench itself stops advancing.
  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pl [8];
    int         n;
    bit         und, found;

    tx_if.tx_req   = 1'b0;
    tx_if.tx_valid = 1'b0;
    tx_if.tx_data  = 8'h00;
    tx_if.tx_last  = 1'b0;

    // Reset is asynchronous: check outputs before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_lane", {20'd0, lane_now()}, {20'd0, P_LP11, 8'h00});
    chk("rst_async_ctl", {28'd0, tx_if.tx_ready, busy, done, underrun}, 32'd0);
    step();
    step();
    @(negedge byte_clk) rst_n = 1'b1;

    // Idle for 20 cycles with no request.
    for (int k = 0; k < 20; k++) begin
      step();
      chk($sformatf("idle_c%0d_lane", k), {20'd0, lane_now()}, {20'd0, P_LP11, 8'h00});
      chk($sformatf("idle_c%0d_ctl", k), {28'd0, tx_if.tx_ready, busy, done, underrun}, 32'd0);
    end
`ifdef DSI_LANE_BYTECNT_EN
    chk("idle_bytecnt", {16'd0, hs_byte_cnt}, 32'd0);
`endif

    // Single byte with last.
    pl = '{8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_burst(pl, 1, 1'b0, 1'b0, "single");
    step();

    // Two bytes then the source stalls.
    pl = '{8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_burst(pl, 2, 1'b1, 1'b0, "stall");
    step();

    // Last byte has bit7 set: trail is all zeros.
    pl = '{8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_burst(pl, 1, 1'b0, 1'b0, "trail80");
    step();

    // No byte at all: trail derives from the sync byte.
    run_burst(pl, 0, 1'b1, 1'b0, "empty");
    step();

    // Back-to-back: request held through the first burst's exit.
    pl = '{8'h11, 8'hC3, 8'h7E, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_burst(pl, 3, 1'b0, 1'b1, "b2b_a");
    pl = '{8'hF0, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_burst(pl, 2, 1'b0, 1'b0, "b2b_b");
    step();

    // Randomized bursts.
    for (int r = 0; r < 6; r++) begin
      n   = int'($urandom_range(1, 8));
      und = 1'($urandom_range(0, 1));
      for (int i = 0; i < 8; i++) pl[i] = 8'($urandom);
      run_burst(pl, n, und, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", r));
    end
    tx_if.tx_req = 1'b0;
    step();
    step();
    step();

    // Reset in the middle of DATA aborts without a trail.
    tx_if.tx_req   = 1'b1;
    tx_if.tx_valid = 1'b1;
    tx_if.tx_data  = 8'h33;
    tx_if.tx_last  = 1'b0;
    step();
    tx_if.tx_req = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      step();
      if (tx_if.tx_ready === 1'b1) found = 1'b1;
    end
    chk("mid_reach_data", {31'd0, found}, 32'd1);
    step();
    chk("mid_hs_active", {31'd0, hs_oe}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_lane", {20'd0, lane_now()}, {20'd0, P_LP11, 8'h00});
    chk("mid_rst_ctl", {28'd0, tx_if.tx_ready, busy, done, underrun}, 32'd0);
`ifdef DSI_LANE_BYTECNT_EN
    chk("mid_rst_bytecnt", {16'd0, hs_byte_cnt}, 32'd0);
`endif
    tx_if.tx_valid = 1'b0;
    @(negedge byte_clk) rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      chk($sformatf("post_rst_c%0d_lane", k), {20'd0, lane_now()}, {20'd0, P_LP11, 8'h00});
      chk($sformatf("post_rst_c%0d_busy", k), {31'd0, busy}, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/dsi_lane_seq.md
Name: dsi_lane_seq

Overview:
Sequencer for one DSI data lane in the byte_clk domain. It runs the LP-to-HS entry sequence, accepts payload bytes through a valid/ready handshake, and drives them as parallel bytes to the DDR serializer. It then sends the HS trail and returns the lane to LP-11. It drives the LP line levels, the HS output enable and the serializer reset.

Parameters:
CW, 8, width of the state timer
T_LPX, 2, byte_clk cycles in LP-01 (range 1..2^CW-1)
T_HS_PREPARE, 3, cycles in LP-00 before HS drive
T_HS_ZERO, 6, cycles of HS-0 (0x00 bytes) before sync
T_HS_TRAIL, 4, cycles of trail byte after last payload byte
T_HS_EXIT, 5, minimum LP-11 cycles after HS before next burst

Ports:
byte_clk  in  1  byte clock; the only clock
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
tx_req  in  1  level request to start a burst
tx_data  in  8  payload byte; bit 0 is transmitted first
tx_valid  in  1  tx_data valid
tx_last  in  1  marks final payload byte, qualified by tx_valid
tx_ready  out  1  high only in DATA state
hs_data  out  8  byte to serializer
hs_oe  out  1  HS driver enable
ser_rst  out  1  active-high serializer reset
lp_p  out  1  LP Dp level
lp_n  out  1  LP Dn level
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on the EXIT to IDLE transition
underrun  out  1  one-cycle pulse when DATA runs out of valid bytes

Behaviour:
- All outputs are registered (Moore); timer and state update on posedge byte_clk.
- On rst_n=0, immediately and asynchronously:
  - state=IDLE, timer=0
  - lp_p=1, lp_n=1, hs_oe=0, ser_rst=1, hs_data=0x00
  - tx_ready=0, busy=0, done=0, underrun=0
- A reset mid-burst aborts the burst; no trail is sent.
- State outputs (lp_p lp_n, hs_oe, ser_rst, hs_data) and transitions:
  - IDLE (1 1, 0, 1): goes to LPX when tx_req=1 is sampled.
  - LPX (0 1, 0, 1): lasts T_LPX cycles.
  - PREP (0 0, 0, 1): lasts T_HS_PREPARE cycles.
  - ZERO (0 0, 1, 0, 0x00): lasts T_HS_ZERO cycles. ser_rst falls on entry, so serializer pair counter starts at 0 on the first HS byte.
  - SYNC (0 0, 1, 0, 0xB8): exactly 1 cycle, then DATA.
  - DATA (0 0, 1, 0): tx_ready=1.
    - On tx_valid=1, hs_data <= tx_data next cycle and the byte is latched as last_byte.
    - If tx_last=1 with that byte, go to TRAIL.
    - If tx_valid=0 in any DATA cycle, pulse underrun and go to TRAIL; the trail then uses the last accepted byte, or 0xB8 if none was accepted.
  - TRAIL (0 0, 1, 0): hs_data = {8{~last_byte[7]}}, constant for T_HS_TRAIL cycles.
  - EXIT (1 1, 0, 1): lasts T_HS_EXIT cycles, then IDLE with done pulse. tx_req is ignored during EXIT.
- tx_ready drops in the same cycle the tx_last byte is accepted; no byte is accepted outside DATA.
- Timer: loaded with parameter-1 on state entry, decrements, and the state exits when timer==0. A value of 1 means a single cycle. Values of 0 are illegal; a simulation assertion fires on them.
- tx_req held high through EXIT starts the next burst on the first IDLE cycle, giving minimum IDLE dwell of 1 cycle.
- The first payload byte appears on hs_data the cycle after SYNC at earliest.

Optional Feature:
DSI_LANE_BYTECNT_EN:
- Defined: adds output hs_byte_cnt[15:0].
  - Cleared to 0 on SYNC entry; increments per accepted payload byte, wrapping at 0xFFFF to 0.
  - Holds its value after the burst until the next SYNC; reset value 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset/idle: rst_n=0 then 1, tx_req=0 for 20 cycles -> lp_p=lp_n=1, hs_oe=0, ser_rst=1, busy=0 throughout.
- Single byte: tx_req pulse, tx_data=0x5A with tx_valid=tx_last=1 held.
  - Lane: LP-01 for 2 cycles, LP-00 for 3, hs_oe=1 with 0x00 for 6, 0xB8 for 1, 0x5A for 1.
  - Trail: 0xFF for 4 cycles (bit7=0); then LP-11 for 5 cycles, done pulse, busy=0.
- Multi-byte with stall: stream 0x01, 0x02, then tx_valid=0 -> underrun pulse, trail 0xFF, and hs_byte_cnt=2 when DSI_LANE_BYTECNT_EN is defined.
- Trail polarity: last byte 0x80 -> trail bytes 0x00 for 4 cycles.
- Back-to-back: tx_req held high for two bursts -> exactly 5 EXIT cycles plus 1 IDLE cycle between hs_oe falling and the next LP-01.
- Reset mid-DATA: rst_n=0 while hs_oe=1 -> same cycle lp=11, hs_oe=0, ser_rst=1, tx_ready=0, with no trail.
